// File: rtl/clk_rst_gen_if.sv
// Channel bus of clk_rst_gen: per-channel divisor programming in, tick/square-wave enables out.
interface clk_rst_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 22
);
    logic [NUM_CH-1:0][DIV_W-1:0] div_i;
    logic [NUM_CH-1:0]            load_i;
    logic                         run_i;
    logic [NUM_CH-1:0]            tick_o;
    logic [NUM_CH-1:0]            sq_o;

    modport master (output div_i, load_i, run_i, input tick_o, sq_o);
    modport slave  (input div_i, load_i, run_i, output tick_o, sq_o);
endinterface

// File: rtl/clk_rst_gen.sv
// Clock-enable divider bank plus sequenced internal reset for the board top.
// Optional CLKGEN_SYNC_EN adds sync_i, which phase-aligns every channel in one cycle.
module clk_rst_gen_ch #(
    parameter int               DIV_W   = 22,
    parameter logic [DIV_W-1:0] DIV_RST = '1
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic             load_i,
`ifdef CLKGEN_SYNC_EN
    input  logic             sync_i,
`endif
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             sq_o
);
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    // Priority: internal reset, then sync, then load, then counting.
    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (clr_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end
`ifdef CLKGEN_SYNC_EN
        else if (sync_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            if (load_i) div_d = div_i;
        end
`endif
        else if (load_i) begin
            div_d = div_i;
            cnt_d = '0;
        end else if (run_i) begin
            if (cnt_q == div_q) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= DIV_RST;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
endmodule

module clk_rst_gen #(
    parameter int               NUM_CH     = 4,
    parameter int               DIV_W      = 22,
    parameter logic [DIV_W-1:0] DIV_RST    = DIV_W'(2097151),
    parameter int               RST_CYCLES = 6,
    parameter int               RST_W      = 3
) (
    input  logic           sys_clk,
    input  logic           reset_n,
    clk_rst_gen_if.slave   bus,
`ifdef CLKGEN_SYNC_EN
    input  logic           sync_i,
`endif
    output logic           rst_o,
    output logic           rst_n_o,
    output logic           ready_o
);
    typedef enum logic [1:0] {SYNC, COUNT, DONE} seq_e;

    localparam logic [RST_W-1:0] RST_END = RST_W'(RST_CYCLES);

    seq_e             state_q, state_d;
    logic [1:0]       sync_q;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             rst_q, rst_d;
    logic             ready_q, ready_d;
    logic [NUM_CH-1:0] tick_w, sq_w;

    // Release synchroniser: assertion is asynchronous, deassertion takes two edges.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[0], 1'b1};
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        rst_d     = rst_q;
        ready_d   = ready_q;
        case (state_q)
            SYNC: begin
                if (sync_q[1]) begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                    state_d   = COUNT;
                end
            end
            COUNT: begin
                if (rst_cnt_q >= RST_END) begin
                    state_d = DONE;
                    rst_d   = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            DONE:    ;
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SYNC;
            rst_cnt_q <= '0;
            rst_q     <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            rst_q     <= rst_d;
            ready_q   <= ready_d;
        end
    end

    assign rst_o   = rst_q;
    assign rst_n_o = ~rst_q;
    assign ready_o = ready_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_rst_gen_ch #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .sys_clk (sys_clk),
            .reset_n (reset_n),
            .clr_i   (rst_q),
            .run_i   (bus.run_i),
            .load_i  (bus.load_i[k]),
`ifdef CLKGEN_SYNC_EN
            .sync_i  (sync_i),
`endif
            .div_i   (bus.div_i[k]),
            .tick_o  (tick_w[k]),
            .sq_o    (sq_w[k])
        );
    end

    assign bus.tick_o = tick_w;
    assign bus.sq_o   = sq_w;
endmodule

// File: tb/tb_clk_rst_gen.sv
// Directed + randomized bench for clk_rst_gen against an arithmetic model of each channel.
module tb_clk_rst_gen;
    localparam int     NUM_CH     = 4;
    localparam int     DIV_W      = 22;
    localparam int     RST_CYCLES = 6;
    localparam int     RST_W      = 3;
    localparam longint DIV_RST    = 2097151;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b1;
    logic rst_o, rst_n_o, ready_o;
`ifdef CLKGEN_SYNC_EN
    logic sync_i = 1'b0;
`endif

    clk_rst_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    clk_rst_gen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_RST(DIV_W'(DIV_RST)),
        .RST_CYCLES(RST_CYCLES), .RST_W(RST_W)
    ) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
`ifdef CLKGEN_SYNC_EN
        .sync_i  (sync_i),
`endif
        .rst_o   (rst_o),
        .rst_n_o (rst_n_o),
        .ready_o (ready_o)
    );

    always #5 sys_clk = ~sys_clk;

    int nvec = 0;
    int nerr = 0;

    // Model: act = counted cycles since the channel's last anchor (reset/load/sync);
    // counter value is act mod (div+1), squares toggled = act / (div+1).
    longint            act [NUM_CH];
    longint            dv  [NUM_CH];
    bit                bsq [NUM_CH];
    logic [NUM_CH-1:0] etick;
    int                rel;
    bit                erst;

    function automatic void model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            act[k] = 0; dv[k] = DIV_RST; bsq[k] = 1'b0;
        end
        etick = '0; rel = 0; erst = 1'b1;
    endfunction

    function automatic void model_edge();
        bit pre;
        pre = erst;
        if (reset_n) begin
            rel++;
            erst = (rel < RST_CYCLES + 3);
        end
        for (int k = 0; k < NUM_CH; k++) begin
            etick[k] = 1'b0;
            if (pre) continue;
`ifdef CLKGEN_SYNC_EN
            if (sync_i) begin
                act[k] = 0; bsq[k] = 1'b0;
                if (bus.load_i[k]) dv[k] = longint'(bus.div_i[k]);
                continue;
            end
`endif
            if (bus.load_i[k]) begin
                bsq[k] = bsq[k] ^ bit'((act[k] / (dv[k] + 1)) % 2);
                act[k] = 0;
                dv[k]  = longint'(bus.div_i[k]);
            end else if (bus.run_i) begin
                etick[k] = ((act[k] % (dv[k] + 1)) == dv[k]);
                act[k]++;
            end
        end
    endfunction

    function automatic logic [NUM_CH-1:0] esq();
        logic [NUM_CH-1:0] s;
        for (int k = 0; k < NUM_CH; k++)
            s[k] = bsq[k] ^ bit'((act[k] / (dv[k] + 1)) % 2);
        return s;
    endfunction

    function automatic bit at_tc(int k);
        return (act[k] % (dv[k] + 1)) == dv[k];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        check({tag, "_tick"}, bus.tick_o, etick);
        check({tag, "_sq"},   bus.sq_o,   esq());
        check({tag, "_rst"},  rst_o,      erst);
        check({tag, "_rstn"}, rst_n_o,    !erst);
        check({tag, "_rdy"},  ready_o,    !erst);
    endtask

    // One clock: model advances on the edge, outputs sampled 1ns later; callers drive after.
    task automatic cyc(input string tag = "cyc");
        @(posedge sys_clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    initial begin
        int n0, n1, nsq0, nboth, w;
        bus.div_i  = '0;
        bus.load_i = '0;
        bus.run_i  = 1'b0;

        // Async reset before any clock edge
        #2 reset_n = 1'b0;
        #1 model_reset();
        chk_all("por");
        repeat (3) cyc("inrst");

        // Release: rst_o must fall exactly 9 edges later
        reset_n = 1'b0;
        reset_n = 1'b1;
        bus.run_i = 1'b1;
        repeat (8) cyc("seq");
        check("rst_before_9", rst_o, 1'b1);
        cyc("seq");
        check("rst_at_9", rst_o, 1'b0);
        check("rdy_at_9", ready_o, 1'b1);

        // ch0 div3, ch1 div0, ch2 div4, ch3 div9
        bus.div_i[0] = 22'd3; bus.div_i[1] = 22'd0;
        bus.div_i[2] = 22'd4; bus.div_i[3] = 22'd9;
        bus.load_i = '1;
        cyc("load");
        bus.load_i = '0;
        n0 = 0; n1 = 0; nsq0 = 0;
        repeat (40) begin
            cyc("run");
            n0 += int'(bus.tick_o[0]);
            n1 += int'(bus.tick_o[1]);
            nsq0 += int'(bus.sq_o[0]);
        end
        check("ch0_ticks40", n0, 10);
        check("ch1_ticks40", n1, 40);
        check("ch0_sq_duty", nsq0, 20);

        // Pause ch2 mid-period at cnt==2
        w = 0;
        while (!((act[2] % 5) == 2) && w < 10) begin cyc("wait2"); w++; end
        check("wait_ch2_cnt2", (act[2] % 5) == 2, 1'b1);
        bus.run_i = 1'b0;
        repeat (3) begin
            cyc("gap");
            check("gap_tick", bus.tick_o, '0);
        end
        bus.run_i = 1'b1;
        repeat (12) cyc("resume");

        // Load ch0 div7 in the same cycle as its terminal count
        w = 0;
        while (!at_tc(0) && w < 10) begin cyc("wait0"); w++; end
        check("wait_ch0_tc", at_tc(0), 1'b1);
        bus.div_i[0] = 22'd7;
        bus.load_i[0] = 1'b1;
        cyc("ldtc");
        bus.load_i = '0;
        check("ldtc_notick", bus.tick_o[0], 1'b0);
        repeat (7) begin
            cyc("ldtc_wait");
            check("ldtc_quiet", bus.tick_o[0], 1'b0);
        end
        cyc("ldtc_next");
        check("ldtc_next_tick", bus.tick_o[0], 1'b1);

        // Randomized: run gaps and reloads with small divisors
        repeat (400) begin
            bus.run_i = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < NUM_CH; k++) begin
                bus.load_i[k] = ($urandom_range(0, 11) == 0);
                bus.div_i[k]  = ($urandom_range(0, 3) == 0) ? DIV_W'($urandom_range(0, 40))
                                                            : DIV_W'($urandom_range(0, 9));
            end
            cyc("rand");
        end
        bus.load_i = '0;
        bus.run_i  = 1'b1;

        // Asynchronous reset mid-operation, then the sequence reruns
        reset_n = 1'b0;
        #1 model_reset();
        chk_all("async");
        check("async_rst", rst_o, 1'b1);
        repeat (2) cyc("inrst2");
        reset_n = 1'b1;
        repeat (9) cyc("seq2");
        check("rdy_rerun", ready_o, 1'b1);
        check("div_back_to_rst", dv[0] == DIV_RST, 1'b1);
        repeat (5) cyc("post");

`ifdef CLKGEN_SYNC_EN
        bus.div_i[0] = 22'd3; bus.div_i[1] = 22'd7;
        bus.load_i = 4'b0011;
        cyc("sload");
        bus.load_i = '0;
        repeat (5) cyc("skew");
        sync_i = 1'b1;
        cyc("sync");
        sync_i = 1'b0;
        nboth = 0; n0 = 0;
        repeat (32) begin
            cyc("aligned");
            n0 += int'(bus.tick_o[0]);
            nboth += int'(bus.tick_o[0] & bus.tick_o[1]);
        end
        check("sync_ch0_ticks", n0, 8);
        check("sync_coincide", nboth, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
